spi_slave_if: RTL and testbench

- Serial front end of the SPI-slave/RAM subsystem.
- Deserialises MOSI frames into 10-bit words (rx_data, rx_valid) for the single-port RAM directly downstream.
- Serialises the RAM's 8-bit read reply (tx_data, tx_valid) back onto MISO.
- Tracks whether a read address has been sent, so a read command alone selects read-address vs read-data.

---
 rtl/shared_pkg.sv | 30 +++
 rtl/spi_slave_if_if.sv | 33 +++
 rtl/spi_tx_serializer.sv | 69 ++++++
 rtl/spi_slave_if.sv | 112 +++++++++++
 tb/tb_spi_slave_if.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/shared_pkg.sv
// Shared types and constants for the SPI-slave/RAM subsystem.
package shared_pkg;

    localparam int unsigned RX_W     = 10;
    localparam int unsigned TX_W     = 8;
    localparam int unsigned RX_CNT_W = $clog2(RX_W + 1);
    localparam int unsigned TX_CNT_W = $clog2(TX_W);

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_e;

    // Word handed to the RAM: op bits on top, address/data payload below.
    typedef struct packed {
        op_e                op;
        logic [RX_W-3:0]    payload;
    } rx_word_t;

endpackage

// File: rtl/spi_slave_if_if.sv
// Bundle of SPI pins plus the RAM-facing word/reply handshake.
interface spi_slave_if_if;
    import shared_pkg::*;

    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    rx_word_t          rx_data;
    logic              rx_valid;
    logic [TX_W-1:0]   tx_data;
    logic              tx_valid;

    modport slave (
        input  SS_n,
        input  MOSI,
        output MISO,
        output rx_data,
        output rx_valid,
        input  tx_data,
        input  tx_valid
    );

    modport master (
        output SS_n,
        output MOSI,
        input  MISO,
        input  rx_data,
        input  rx_valid,
        output tx_data,
        output tx_valid
    );

endinterface

// File: rtl/spi_tx_serializer.sv
// Loads one RAM read byte and shifts it out MSB first, one bit per clock.
module spi_tx_serializer
    import shared_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            abort_i,
    input  logic [TX_W-1:0] data_i,
    output logic            miso_o,
    output logic            done_o
);

    logic [TX_W-1:0]     sh_q,   sh_d;
    logic [TX_CNT_W-1:0] rem_q,  rem_d;
    logic                busy_q, busy_d;
    logic                miso_q, miso_d;
    logic                done_q, done_d;

    // Abort beats load; after the last bit the line returns to 0 and done pulses.
    always_comb begin
        sh_d   = sh_q;
        rem_d  = rem_q;
        busy_d = busy_q;
        miso_d = miso_q;
        done_d = 1'b0;
        if (abort_i) begin
            sh_d   = '0;
            rem_d  = '0;
            busy_d = 1'b0;
            miso_d = 1'b0;
        end else if (load_i) begin
            miso_d = data_i[TX_W-1];
            sh_d   = {data_i[TX_W-2:0], 1'b0};
            rem_d  = TX_CNT_W'(TX_W - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (rem_q != '0) begin
                miso_d = sh_q[TX_W-1];
                sh_d   = {sh_q[TX_W-2:0], 1'b0};
                rem_d  = rem_q - TX_CNT_W'(1);
            end else begin
                miso_d = 1'b0;
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            rem_q  <= '0;
            busy_q <= 1'b0;
            miso_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            rem_q  <= rem_d;
            busy_q <= busy_d;
            miso_q <= miso_d;
            done_q <= done_d;
        end
    end

    assign miso_o = miso_q;
    assign done_o = done_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: decodes command frames into RAM words and returns read data on MISO.
module spi_slave_if
    import shared_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    spi_slave_if_if.slave  spi_bus
);

    spi_state_e          state_q, state_d;
    logic [RX_CNT_W-1:0] cnt_q, cnt_d;
    logic [RX_W-1:0]     rx_sh_q, rx_sh_d;
    rx_word_t            rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rd_addr_seen_q, rd_addr_seen_d;
    logic                tx_sent_q, tx_sent_d;
    logic                tx_load_c;
    logic                tx_done;
    logic                miso;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rx_sh_d        = rx_sh_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_seen_d = rd_addr_seen_q;
        tx_sent_d      = tx_sent_q;
        tx_load_c      = 1'b0;

        if (tx_done) begin
            rd_addr_seen_d = 1'b0;
        end

        // Deselect ends any frame at once, even on the edge carrying the last bit.
        if (state_q != IDLE && spi_bus.SS_n) begin
            state_d   = IDLE;
            cnt_d     = '0;
            tx_sent_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!spi_bus.SS_n) begin
                        state_d = CHK_CMD;
                    end
                end
                CHK_CMD: begin
                    cnt_d = '0;
                    if (!spi_bus.MOSI) begin
                        state_d = WRITE;
                    end else if (rd_addr_seen_q) begin
                        state_d = READ_DATA;
                    end else begin
                        state_d = READ_ADD;
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (cnt_q != RX_CNT_W'(RX_W)) begin
                        rx_sh_d = {rx_sh_q[RX_W-2:0], spi_bus.MOSI};
                        cnt_d   = cnt_q + RX_CNT_W'(1);
                        if (cnt_q == RX_CNT_W'(RX_W - 1)) begin
                            rx_data_d  = rx_word_t'({rx_sh_q[RX_W-2:0], spi_bus.MOSI});
                            rx_valid_d = 1'b1;
                            if (state_q == READ_ADD) begin
                                rd_addr_seen_d = 1'b1;
                            end
                        end
                    end else if (state_q == READ_DATA && !tx_sent_q && spi_bus.tx_valid) begin
                        tx_load_c = 1'b1;
                        tx_sent_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rx_sh_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            tx_sent_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rx_sh_q        <= rx_sh_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            tx_sent_q      <= tx_sent_d;
        end
    end

    spi_tx_serializer u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (tx_load_c),
        .abort_i (spi_bus.SS_n),
        .data_i  (spi_bus.tx_data),
        .miso_o  (miso),
        .done_o  (tx_done)
    );

    assign spi_bus.MISO     = miso;
    assign spi_bus.rx_data  = rx_data_q;
    assign spi_bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: write, read-address/read-data, abort and reset cases.
module tb_spi_slave_if;
    import shared_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    spi_slave_if_if spi_bus ();

    spi_slave_if dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .spi_bus (spi_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the following falling edge.
    task automatic step(input logic ss, input logic mosi);
        spi_bus.SS_n = ss;
        spi_bus.MOSI = mosi;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic cmd, input logic [9:0] w, input spi_state_e exp_st);
        step(1'b0, 1'b0);
        step(1'b0, cmd);
        chk("frame_state", 32'(dut.state_q), 32'(exp_st));
        for (int i = 9; i >= 0; i--) begin
            step(1'b0, w[i]);
            chk("frame_rx_valid", 32'(spi_bus.rx_valid), 32'(i == 0));
        end
        chk("frame_rx_data", 32'(spi_bus.rx_data), 32'(w));
    endtask

    initial begin
        logic [7:0] rd_byte;
        checks   = 0;
        failures = 0;
        rst_n            = 1'b0;
        spi_bus.SS_n     = 1'b1;
        spi_bus.MOSI     = 1'b0;
        spi_bus.tx_data  = 8'h00;
        spi_bus.tx_valid = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_rx_data",  32'(spi_bus.rx_data), 32'h0);
        chk("rst_rx_valid", 32'(spi_bus.rx_valid), 32'h0);
        chk("rst_miso",     32'(spi_bus.MISO), 32'h0);
        chk("rst_state",    32'(dut.state_q), 32'(IDLE));
        chk("rst_rd_seen",  32'(dut.rd_addr_seen_q), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write-address frame; a stray tx_valid here must not reach MISO.
        send_frame(1'b0, 10'h0A5, WRITE);
        chk("wa_miso", 32'(spi_bus.MISO), 32'h0);
        spi_bus.tx_data  = 8'hFF;
        spi_bus.tx_valid = 1'b1;
        step(1'b0, 1'b0);
        spi_bus.tx_valid = 1'b0;
        chk("wa_txv_ignored", 32'(spi_bus.MISO), 32'h0);
        chk("wa_single_pulse", 32'(spi_bus.rx_valid), 32'h0);
        step(1'b1, 1'b0);
        chk("wa_idle", 32'(dut.state_q), 32'(IDLE));
        chk("wa_hold", 32'(spi_bus.rx_data), 32'h0A5);

        // Write-data frame
        send_frame(1'b0, 10'h1F0, WRITE);
        chk("wd_rd_seen", 32'(dut.rd_addr_seen_q), 32'h0);
        step(1'b1, 1'b0);

        // Read address then read data
        send_frame(1'b1, 10'h203, READ_ADD);
        chk("ra_rd_seen", 32'(dut.rd_addr_seen_q), 32'h1);
        step(1'b1, 1'b0);
        chk("ra_rd_seen_kept", 32'(dut.rd_addr_seen_q), 32'h1);
        send_frame(1'b1, 10'h3A7, READ_DATA);

        rd_byte          = 8'hC5;
        spi_bus.tx_data  = rd_byte;
        spi_bus.tx_valid = 1'b1;
        step(1'b0, 1'b0);
        spi_bus.tx_valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            chk("rd_miso_bit", 32'(spi_bus.MISO), 32'(rd_byte[i]));
            if (i > 0) step(1'b0, 1'b0);
        end
        chk("rd_seen_during_tx", 32'(dut.rd_addr_seen_q), 32'h1);
        step(1'b0, 1'b0);
        chk("rd_miso_idle", 32'(spi_bus.MISO), 32'h0);
        step(1'b0, 1'b0);
        chk("rd_seen_cleared", 32'(dut.rd_addr_seen_q), 32'h0);
        chk("rd_hold_state", 32'(dut.state_q), 32'(READ_DATA));
        spi_bus.tx_valid = 1'b1;
        step(1'b0, 1'b0);
        spi_bus.tx_valid = 1'b0;
        chk("rd_no_retx", 32'(spi_bus.MISO), 32'h0);
        step(1'b1, 1'b0);
        chk("rd_idle", 32'(dut.state_q), 32'(IDLE));

        // Abort after 6 data bits of a write
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1);
            chk("ab_no_valid", 32'(spi_bus.rx_valid), 32'h0);
        end
        step(1'b1, 1'b0);
        chk("ab_idle", 32'(dut.state_q), 32'(IDLE));
        chk("ab_rx_valid", 32'(spi_bus.rx_valid), 32'h0);
        chk("ab_rx_data", 32'(spi_bus.rx_data), 32'h3A7);
        send_frame(1'b0, 10'h155, WRITE);
        step(1'b1, 1'b0);

        // SS_n rises on the edge carrying bit 10
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1);
        end
        step(1'b1, 1'b1);
        chk("sim_rx_valid", 32'(spi_bus.rx_valid), 32'h0);
        chk("sim_rx_data", 32'(spi_bus.rx_data), 32'h155);
        chk("sim_idle", 32'(dut.state_q), 32'(IDLE));
        step(1'b1, 1'b0);
        chk("sim_rx_valid_late", 32'(spi_bus.rx_valid), 32'h0);

        // Reset during MISO bit 3
        send_frame(1'b1, 10'h2AA, READ_ADD);
        step(1'b1, 1'b0);
        send_frame(1'b1, 10'h3FF, READ_DATA);
        spi_bus.tx_data  = 8'h08;
        spi_bus.tx_valid = 1'b1;
        step(1'b0, 1'b0);
        spi_bus.tx_valid = 1'b0;
        repeat (4) step(1'b0, 1'b0);
        chk("rm_bit3", 32'(spi_bus.MISO), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_miso", 32'(spi_bus.MISO), 32'h0);
        chk("rm_rx_valid", 32'(spi_bus.rx_valid), 32'h0);
        chk("rm_state", 32'(dut.state_q), 32'(IDLE));
        chk("rm_rd_seen", 32'(dut.rd_addr_seen_q), 32'h0);
        chk("rm_rx_data", 32'(spi_bus.rx_data), 32'h0);
        spi_bus.SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame after reset decodes normally
        send_frame(1'b0, 10'h0C3, WRITE);
        step(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
